viterbi_acs_unit: RTL and testbench

- Trellis stage placed directly after the symbol input buffer of the Viterbi decoder.
- On a start pulse it captures eight 2-bit received symbol pairs. It then steps them through a 4-state rate-1/2 trellis (K=3, generators 7/5 octal), one pair per cycle, running hard-decision branch-metric and add-compare-select (ACS).
- Each step emits 4 survivor decision bits for the downstream traceback stage.
- After the last step it reports the best final state and its path metric.

---
 rtl/viterbi_acs_unit.sv | 205 ++++++++++++++++++++
 tb/tb_viterbi_acs_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_acs_unit.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_acs_unit
// Description : Captures eight received 2-bit symbol pairs and steps them
//               through a 4-state K=3 (7/5 octal) rate-1/2 trellis, one pair
//               per cycle.  Each step runs hard-decision branch metrics and
//               add-compare-select, emitting 4 survivor decision bits.  After
//               the last step the best final state and its metric are
//               reported with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_acs_unit #(
    parameter int PM_W    = 6,
    parameter int PM_INIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      bit_pair_0,
    input  logic [1:0]      bit_pair_1,
    input  logic [1:0]      bit_pair_2,
    input  logic [1:0]      bit_pair_3,
    input  logic [1:0]      bit_pair_4,
    input  logic [1:0]      bit_pair_5,
    input  logic [1:0]      bit_pair_6,
    input  logic [1:0]      bit_pair_7,
    output logic            busy,
    output logic            dec_valid,
    output logic [2:0]      dec_step,
    output logic [3:0]      dec_bits,
    output logic            done,
    output logic [1:0]      best_state,
    output logic [PM_W-1:0] best_metric
);

    // Saturation ceiling for path metrics, in native and extended widths.
    localparam logic [PM_W-1:0] c_PM_MAX     = {PM_W{1'b1}};
    localparam logic [PM_W+1:0] c_PM_MAX_EXT = {2'b00, {PM_W{1'b1}}};
    localparam logic [PM_W-1:0] c_PM_INIT    = PM_W'(PM_INIT);
    localparam logic [2:0]      c_LAST_STEP  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_step;
    logic [1:0]      r_pairs [0:7];
    logic [PM_W-1:0] r_pm    [0:3];

    logic            r_busy;
    logic            r_dec_valid;
    logic [2:0]      r_dec_step;
    logic [3:0]      r_dec_bits;
    logic            r_done;
    logic [1:0]      r_best_state;
    logic [PM_W-1:0] r_best_metric;

    logic [1:0]      w_pairs_in [0:7];
    logic [1:0]      w_pair;
    logic [PM_W-1:0] w_npm      [0:3];
    logic [3:0]      w_dec;
    logic [1:0]      w_best_state;
    logic [PM_W-1:0] w_best_metric;

    assign w_pairs_in[0] = bit_pair_0;
    assign w_pairs_in[1] = bit_pair_1;
    assign w_pairs_in[2] = bit_pair_2;
    assign w_pairs_in[3] = bit_pair_3;
    assign w_pairs_in[4] = bit_pair_4;
    assign w_pairs_in[5] = bit_pair_5;
    assign w_pairs_in[6] = bit_pair_6;
    assign w_pairs_in[7] = bit_pair_7;

    // Pair consumed by the current trellis step.
    assign w_pair = r_pairs[r_step];

    // One ACS butterfly half per next state.  Next state ns={u,s1} is reached
    // from predecessors {ns[0],0} and {ns[0],1} with input u=ns[1]; the
    // expected code for the transition is c0=u^s1^s0, c1=u^s0.
    generate
        for (genvar n = 0; n < 4; n++) begin : g_acs
            localparam logic [1:0] c_NS   = 2'(n);
            localparam logic       c_U    = c_NS[1];
            localparam logic [1:0] c_P0   = {c_NS[0], 1'b0};
            localparam logic [1:0] c_P1   = {c_NS[0], 1'b1};
            localparam logic [1:0] c_EXP0 = {c_U ^ c_P0[1] ^ c_P0[0], c_U ^ c_P0[0]};
            localparam logic [1:0] c_EXP1 = {c_U ^ c_P1[1] ^ c_P1[0], c_U ^ c_P1[0]};

            logic [1:0]      w_diff0;
            logic [1:0]      w_diff1;
            logic [1:0]      w_bm0;
            logic [1:0]      w_bm1;
            logic [PM_W+1:0] w_sum0;
            logic [PM_W+1:0] w_sum1;
            logic [PM_W-1:0] w_cand0;
            logic [PM_W-1:0] w_cand1;

            // Hamming distance between received and expected pair.
            assign w_diff0 = w_pair ^ c_EXP0;
            assign w_diff1 = w_pair ^ c_EXP1;
            assign w_bm0   = {1'b0, w_diff0[1]} + {1'b0, w_diff0[0]};
            assign w_bm1   = {1'b0, w_diff1[1]} + {1'b0, w_diff1[0]};

            // Add in extended width, then clamp at the metric ceiling.
            assign w_sum0  = {2'b00, r_pm[c_P0]} + {{PM_W{1'b0}}, w_bm0};
            assign w_sum1  = {2'b00, r_pm[c_P1]} + {{PM_W{1'b0}}, w_bm1};
            assign w_cand0 = (w_sum0 > c_PM_MAX_EXT) ? c_PM_MAX : w_sum0[PM_W-1:0];
            assign w_cand1 = (w_sum1 > c_PM_MAX_EXT) ? c_PM_MAX : w_sum1[PM_W-1:0];

            // Strictly-smaller p1 wins; ties stay with p0.
            assign w_dec[n] = (w_cand1 < w_cand0);
            assign w_npm[n] = w_dec[n] ? w_cand1 : w_cand0;
        end
    endgenerate

    // Minimum over the current path metrics; lowest index wins ties.
    always_comb begin
        w_best_state  = 2'd0;
        w_best_metric = r_pm[0];
        for (int i = 1; i < 4; i++) begin
            if (r_pm[i] < w_best_metric) begin
                w_best_metric = r_pm[i];
                w_best_state  = 2'(i);
            end
        end
    end

    // Block sequencer: capture, eight ACS steps, final best-state report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_step        <= 3'd0;
            r_busy        <= 1'b0;
            r_dec_valid   <= 1'b0;
            r_dec_step    <= 3'd0;
            r_dec_bits    <= 4'd0;
            r_done        <= 1'b0;
            r_best_state  <= 2'd0;
            r_best_metric <= '0;
            for (int i = 0; i < 8; i++) begin
                r_pairs[i] <= 2'd0;
            end
            for (int i = 0; i < 4; i++) begin
                r_pm[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < 8; i++) begin
                            r_pairs[i] <= w_pairs_in[i];
                        end
                        r_pm[0] <= '0;
                        r_pm[1] <= c_PM_INIT;
                        r_pm[2] <= c_PM_INIT;
                        r_pm[3] <= c_PM_INIT;
                        r_step  <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    for (int i = 0; i < 4; i++) begin
                        r_pm[i] <= w_npm[i];
                    end
                    r_dec_valid <= 1'b1;
                    r_dec_step  <= r_step;
                    r_dec_bits  <= w_dec;
                    r_step      <= r_step + 3'd1;
                    if (r_step == c_LAST_STEP) begin
                        r_state <= S_FINAL;
                    end
                end

                S_FINAL: begin
                    r_dec_valid   <= 1'b0;
                    r_best_state  <= w_best_state;
                    r_best_metric <= w_best_metric;
                    r_done        <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign dec_valid   = r_dec_valid;
    assign dec_step    = r_dec_step;
    assign dec_bits    = r_dec_bits;
    assign done        = r_done;
    assign best_state  = r_best_state;
    assign best_metric = r_best_metric;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_acs_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_viterbi_acs_unit
// Description : Directed, table-driven bench for viterbi_acs_unit.  Two
//               instances (default widths and PM_W=4/PM_INIT=15) share one
//               stimulus.  Final results are checked against hand-derived
//               values; survivor bits against a forward-trellis model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_acs_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] bp [0:7];

    logic       a_busy, a_dv, a_done;
    logic [2:0] a_step;
    logic [3:0] a_bits;
    logic [1:0] a_bst;
    logic [5:0] a_bm;

    logic       b_busy, b_dv, b_done;
    logic [2:0] b_step;
    logic [3:0] b_bits;
    logic [1:0] b_bst;
    logic [3:0] b_bm;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    viterbi_acs_unit #(.PM_W(6), .PM_INIT(16)) u_dut_a (
        .clk(clk), .rst(rst), .start(start),
        .bit_pair_0(bp[0]), .bit_pair_1(bp[1]), .bit_pair_2(bp[2]), .bit_pair_3(bp[3]),
        .bit_pair_4(bp[4]), .bit_pair_5(bp[5]), .bit_pair_6(bp[6]), .bit_pair_7(bp[7]),
        .busy(a_busy), .dec_valid(a_dv), .dec_step(a_step), .dec_bits(a_bits),
        .done(a_done), .best_state(a_bst), .best_metric(a_bm)
    );

    viterbi_acs_unit #(.PM_W(4), .PM_INIT(15)) u_dut_b (
        .clk(clk), .rst(rst), .start(start),
        .bit_pair_0(bp[0]), .bit_pair_1(bp[1]), .bit_pair_2(bp[2]), .bit_pair_3(bp[3]),
        .bit_pair_4(bp[4]), .bit_pair_5(bp[5]), .bit_pair_6(bp[6]), .bit_pair_7(bp[7]),
        .busy(b_busy), .dec_valid(b_dv), .dec_step(b_step), .dec_bits(b_bits),
        .done(b_done), .best_state(b_bst), .best_metric(b_bm)
    );

    typedef struct {
        logic [15:0] word;
        int          st;
        int          met;
        bit          hand;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_pairs(input logic [15:0] w);
        for (int i = 0; i < 8; i++) begin
            bp[i] = w[15-2*i -: 2];
        end
    endtask

    // Forward trellis walk: every (state, input) edge relaxes its next state;
    // source states are visited in ascending order so equal candidates keep
    // the even (p0) predecessor.
    task automatic model_run(input logic [15:0] w, input int pmw, input int init,
                             output logic [31:0] bits, output int bst, output int bmet);
        int pm [4];
        int npm [4];
        int mx, c0, c1, bm, cand, ns, s1, s0;
        logic [1:0] pr;
        mx = (1 << pmw) - 1;
        pm[0] = 0; pm[1] = init; pm[2] = init; pm[3] = init;
        bits = '0;
        for (int st = 0; st < 8; st++) begin
            pr = w[15-2*st -: 2];
            for (int n = 0; n < 4; n++) npm[n] = 1 << 30;
            for (int s = 0; s < 4; s++) begin
                s1 = s / 2;
                s0 = s % 2;
                for (int u = 0; u < 2; u++) begin
                    c0   = u ^ s1 ^ s0;
                    c1   = u ^ s0;
                    bm   = ((int'(pr[1]) != c0) ? 1 : 0) + ((int'(pr[0]) != c1) ? 1 : 0);
                    cand = pm[s] + bm;
                    if (cand > mx) cand = mx;
                    ns = u * 2 + s1;
                    if (cand < npm[ns]) begin
                        npm[ns] = cand;
                        bits[st*4+ns] = (s0 == 1);
                    end
                end
            end
            for (int n = 0; n < 4; n++) pm[n] = npm[n];
        end
        bst = 0;
        bmet = pm[0];
        for (int n = 1; n < 4; n++) begin
            if (pm[n] < bmet) begin
                bmet = pm[n];
                bst = n;
            end
        end
    endtask

    // Starts a block from the current negedge and checks it through the
    // done cycle; returns at the negedge where done is visible.
    task automatic run_block(input logic [15:0] w, input int hs, input int hm,
                             input bit hand, input string tag);
        logic [31:0] ba, bb;
        int sa, ma, sb, mb;
        model_run(w, 6, 16, ba, sa, ma);
        model_run(w, 4, 15, bb, sb, mb);
        if (hand) begin
            sa = hs; ma = hm; sb = hs; mb = hm;
        end
        set_pairs(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_pairs(~w);
        chk({tag, " busy_a after start"}, int'(a_busy), 1);
        chk({tag, " busy_b after start"}, int'(b_busy), 1);
        chk({tag, " dec_valid before step0"}, int'(a_dv), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("%s dec_valid_a s%0d", tag, k), int'(a_dv), 1);
            chk($sformatf("%s dec_valid_b s%0d", tag, k), int'(b_dv), 1);
            chk($sformatf("%s dec_step s%0d", tag, k), int'(a_step), k);
            chk($sformatf("%s dec_bits_a s%0d", tag, k), int'(a_bits), int'(ba[k*4 +: 4]));
            chk($sformatf("%s dec_bits_b s%0d", tag, k), int'(b_bits), int'(bb[k*4 +: 4]));
            chk($sformatf("%s done low s%0d", tag, k), int'(a_done), 0);
        end
        @(negedge clk);
        chk({tag, " done_a"}, int'(a_done), 1);
        chk({tag, " done_b"}, int'(b_done), 1);
        chk({tag, " busy_a at done"}, int'(a_busy), 0);
        chk({tag, " dec_valid at done"}, int'(a_dv), 0);
        chk({tag, " dec_step hold"}, int'(a_step), 7);
        chk({tag, " dec_bits hold"}, int'(a_bits), int'(ba[31:28]));
        chk({tag, " best_state_a"}, int'(a_bst), sa);
        chk({tag, " best_metric_a"}, int'(a_bm), ma);
        chk({tag, " best_state_b"}, int'(b_bst), sb);
        chk({tag, " best_metric_b"}, int'(b_bm), mb);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy_a"}, int'(a_busy), 0);
        chk({tag, " dec_valid_a"}, int'(a_dv), 0);
        chk({tag, " dec_step_a"}, int'(a_step), 0);
        chk({tag, " dec_bits_a"}, int'(a_bits), 0);
        chk({tag, " done_a"}, int'(a_done), 0);
        chk({tag, " best_state_a"}, int'(a_bst), 0);
        chk({tag, " best_metric_a"}, int'(a_bm), 0);
        chk({tag, " outputs_b"}, int'({b_busy, b_dv, b_step, b_bits, b_done, b_bst, b_bm}), 0);
    endtask

    initial begin
        vec_t tbl [6];
        int   dcount, dcycle;

        tbl[0] = '{16'h0000, 0, 0, 1'b1};
        tbl[1] = '{16'hE170, 0, 0, 1'b1};
        tbl[2] = '{16'h6170, 0, 1, 1'b1};
        tbl[3] = '{16'hFFFF, 1, 3, 1'b1};
        tbl[4] = '{16'h5A3C, 0, 0, 1'b0};
        tbl[5] = '{16'h9B27, 0, 0, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        set_pairs(16'h0000);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table of blocks, each followed by a done-release / hold check.
        for (int v = 0; v < 6; v++) begin
            run_block(tbl[v].word, tbl[v].st, tbl[v].met, tbl[v].hand,
                      $sformatf("vec%0d", v));
            @(negedge clk);
            chk($sformatf("vec%0d done pulse ends", v), int'(a_done), 0);
            chk($sformatf("vec%0d best_state held", v), int'(a_bst), tbl[v].hand ? tbl[v].st : int'(a_bst));
            chk($sformatf("vec%0d busy idle", v), int'(a_busy), 0);
        end

        // start pulses sampled at E3 and E8 of a running block are dropped.
        set_pairs(16'hE170);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_pairs(16'hFFFF);
        dcount = 0;
        dcycle = -1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (a_done) begin
                dcount++;
                dcycle = c;
                chk("ignored-start best_state", int'(a_bst), 0);
                chk("ignored-start best_metric", int'(a_bm), 0);
            end
            start = (c == 2 || c == 7) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("ignored-start done count", dcount, 1);
        chk("ignored-start done cycle", dcycle, 9);

        // Second block begins in the done cycle of the first.
        run_block(16'hE170, 0, 0, 1'b1, "b2b_first");
        run_block(16'h6170, 0, 1, 1'b1, "b2b_second");
        @(negedge clk);

        // Reset at the edge that would process step 4.
        set_pairs(16'hFFFF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset dec_step", int'(a_step), 3);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midblock reset");
        rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a_done || b_done || a_dv || a_busy) dcount++;
        end
        chk("no activity after reset", dcount, 0);
        run_block(16'hFFFF, 1, 3, 1'b1, "post-reset");
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got simulation time %0t expected end before limit", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
